// File: rtl/jbi_timer_array_pkg.sv
// Shared definitions for the JBI timeout timer bank: default widths and
// the per-channel state encoding.
package jbi_timer_array_pkg;

  localparam int NUM_CH_DEF = 32;
  localparam int ID_W_DEF   = 5;
  localparam int CNT_W_DEF  = 4;

  // Channel state encoding; 2'b11 is never legal.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARMED   = 2'b01;
  localparam logic [1:0] ST_EXPIRED = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

endpackage

// File: rtl/jbi_timer_array_if.sv
// Start/stop request and timeout-report handshake bundle for the timer bank.
interface jbi_timer_array_if #(
  parameter int ID_W = 5
);
  logic            start_vld;
  logic [ID_W-1:0] start_id;
  logic            stop_vld;
  logic [ID_W-1:0] stop_id;
  logic            to_vld;
  logic [ID_W-1:0] to_id;
  logic            to_ack;

  // Requester side: issues start/stop, consumes timeout reports.
  modport master (
    output start_vld, start_id, stop_vld, stop_id, to_ack,
    input  to_vld, to_id
  );

  // Timer bank side.
  modport slave (
    input  start_vld, start_id, stop_vld, stop_id, to_ack,
    output to_vld, to_id
  );
endinterface

// File: rtl/jbi_timer_chan.sv
// One timeout channel: IDLE/ARMED/EXPIRED state, saturating tick counter and
// a pending flag that stays set until the expiry is acknowledged or stopped.
module jbi_timer_chan
  import jbi_timer_array_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_thr,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_ack,
  output logic             o_busy,
  output logic             o_err,
  output logic             o_pend
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;

  logic [CNT_W:0]   w_inc;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_hit;

  // One extra bit on the increment: a saturated counter yields 2^CNT_W,
  // which can never equal a CNT_W-bit threshold, so it cannot expire.
  assign w_inc     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_cnt_sat = w_inc[CNT_W] ? r_cnt : w_inc[CNT_W-1:0];
  assign w_hit     = (i_thr != '0) && (w_inc == {1'b0, i_thr});

  // Channel state machine; stop dominates tick, start only acts from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
          end
        end
        ST_ARMED: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (i_tick) begin
            r_cnt <= w_cnt_sat;
            if (w_hit) begin
              r_state <= ST_EXPIRED;
              r_pend  <= 1'b1;
            end
          end
        end
        ST_EXPIRED: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
          end else if (i_ack) begin
            r_pend <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

  // Simulation monitor: the unused encoding must never be reached.
  always @(posedge clk) begin
    if (!rst) assert (r_state != ST_ILLEGAL) else $error("jbi_timer_chan: illegal state");
  end

  assign o_busy = r_state != ST_IDLE;
  assign o_err  = r_state == ST_EXPIRED;
  assign o_pend = r_pend;

endmodule

// File: rtl/jbi_timer_array.sv
// Bank of NUM_CH transaction-timeout timers indexed by JID. Holds request
// decode, protocol-violation detection, the lowest-index pending selector and
// the one-at-a-time timeout report register.
module jbi_timer_array
  import jbi_timer_array_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic [CNT_W-1:0]     i_timeout_ticks,
  jbi_timer_array_if.slave     if_bus,
  output logic [NUM_CH-1:0]    o_busy,
  output logic [NUM_CH-1:0]    o_error,
  output logic                 o_proto_err
);

  logic [NUM_CH-1:0] w_start_oh;
  logic [NUM_CH-1:0] w_stop_oh;
  logic [NUM_CH-1:0] w_ack_oh;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_err;
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_cand;
  logic              w_sel_vld;
  logic [ID_W-1:0]   w_sel_id;
  logic              w_ack;

  logic              r_to_vld;
  logic [ID_W-1:0]   r_to_id;
  logic              r_proto;

  assign w_start_oh = if_bus.start_vld ? (NUM_CH'(1) << if_bus.start_id) : '0;
  assign w_stop_oh  = if_bus.stop_vld  ? (NUM_CH'(1) << if_bus.stop_id)  : '0;
  assign w_ack      = r_to_vld && if_bus.to_ack;
  assign w_ack_oh   = w_ack ? (NUM_CH'(1) << r_to_id) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    jbi_timer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (i_tick),
      .i_thr   (i_timeout_ticks),
      .i_start (w_start_oh[g]),
      .i_stop  (w_stop_oh[g]),
      .i_ack   (w_ack_oh[g]),
      .o_busy  (w_busy[g]),
      .o_err   (w_err[g]),
      .o_pend  (w_pend[g])
    );
  end

  // Lowest-index pending channel; a channel being stopped this cycle is
  // skipped so a report is never raised for a channel that is going IDLE.
  always_comb begin
    w_cand    = w_pend & ~w_stop_oh;
    w_sel_vld = |w_cand;
    w_sel_id  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_cand[i]) w_sel_id = ID_W'(i);
    end
  end

  // Violation pulse: start on a busy channel or stop on an idle one. On a
  // same-id collision the channel logic lets exactly one of them act, and
  // the other lands here.
  always_ff @(posedge clk) begin
    if (rst) r_proto <= 1'b0;
    else     r_proto <= (if_bus.start_vld && w_busy[if_bus.start_id]) ||
                        (if_bus.stop_vld  && !w_busy[if_bus.stop_id]);
  end

  // Report register: load from the selector when idle, freeze while holding,
  // leave on ack or on a stop of the reported channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_vld <= 1'b0;
      r_to_id  <= '0;
    end else if (!r_to_vld) begin
      if (w_sel_vld) begin
        r_to_vld <= 1'b1;
        r_to_id  <= w_sel_id;
      end
    end else if (if_bus.to_ack) begin
      r_to_vld <= 1'b0;
    end else if (if_bus.stop_vld && (if_bus.stop_id == r_to_id)) begin
      r_to_vld <= 1'b0;
    end
  end

  assign if_bus.to_vld = r_to_vld;
  assign if_bus.to_id  = r_to_id;
  assign o_busy        = w_busy;
  assign o_error       = w_err;
  assign o_proto_err   = r_proto;

endmodule

// File: tb/tb_jbi_timer_array.sv
// Directed plus randomized checks of the timer bank against a per-cycle
// behavioural model of channel states, tick counts and the report queue.
module tb_jbi_timer_array;
  localparam int NUM_CH = 32;
  localparam int ID_W   = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic [CNT_W-1:0]  thr;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] error;
  logic              proto_err;

  jbi_timer_array_if #(.ID_W(ID_W)) bus ();

  jbi_timer_array #(.NUM_CH(NUM_CH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_tick          (tick),
    .i_timeout_ticks (thr),
    .if_bus          (bus),
    .o_busy          (busy),
    .o_error         (error),
    .o_proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 armed, 2 expired.
  int m_state [NUM_CH];
  int m_cnt   [NUM_CH];
  bit m_pend  [NUM_CH];
  bit m_vld;
  int m_id;
  bit m_proto;

  int n_assert = 0;
  int n_fail   = 0;
  int n_proto  = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_busy();
    logic [NUM_CH-1:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = (m_state[i] != 0);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_err();
    logic [NUM_CH-1:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = (m_state[i] == 2);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_state[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
    end
    m_vld = 0; m_id = 0; m_proto = 0;
  endtask

  task automatic model_step(bit tk, bit sv, int sid, bit pv, int pid, bit ak, int th);
    bit found;
    m_proto = (sv && m_state[sid] != 0) || (pv && m_state[pid] == 0);
    // report queue uses the pending set as it stood before this edge
    if (!m_vld) begin
      found = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && m_pend[i] && !(pv && pid == i)) begin
          found = 1; m_vld = 1; m_id = i;
        end
      end
    end else if (ak) begin
      m_pend[m_id] = 0; m_vld = 0;
    end else if (pv && pid == m_id) begin
      m_vld = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      case (m_state[i])
        0: if (sv && sid == i) begin m_state[i] = 1; m_cnt[i] = 0; end
        1: begin
          if (pv && pid == i) begin
            m_state[i] = 0; m_cnt[i] = 0;
          end else if (tk) begin
            if (th != 0 && m_cnt[i] + 1 == th) begin
              m_state[i] = 2; m_pend[i] = 1;
            end
            m_cnt[i] = (m_cnt[i] == CMAX) ? CMAX : m_cnt[i] + 1;
          end
        end
        default: if (pv && pid == i) begin
          m_state[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
        end
      endcase
    end
  endtask

  task automatic step(bit tk, bit sv, int sid, bit pv, int pid, bit ak);
    tick = tk;
    bus.start_vld = sv; bus.start_id = ID_W'(sid);
    bus.stop_vld  = pv; bus.stop_id  = ID_W'(pid);
    bus.to_ack    = ak;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(tk, sv, sid, pv, pid, ak, int'(thr));
    #1;
    chk("busy",   busy,        exp_busy());
    chk("error",  error,       exp_err());
    chk("to_vld", bus.to_vld,  m_vld);
    chk("to_id",  bus.to_id,   m_id);
    chk("proto",  proto_err,   m_proto);
    if (proto_err === 1'b1) n_proto++;
    tick = 0; bus.start_vld = 0; bus.stop_vld = 0; bus.to_ack = 0;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask

  initial begin
    rst = 1; tick = 0; thr = '0;
    bus.start_vld = 0; bus.start_id = '0;
    bus.stop_vld  = 0; bus.stop_id  = '0;
    bus.to_ack    = 0;
    model_reset();
    idle();
    chk("rst_busy",  busy,       '0);
    chk("rst_error", error,      '0);
    chk("rst_vld",   bus.to_vld, 0);
    chk("rst_proto", proto_err,  0);
    rst = 0;
    idle();

    // Single expiry, report, ack, stop
    thr = 3;
    step(0, 1, 5, 0, 0, 0);
    chk("tp1_busy5", busy[5], 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("tp1_noerr", error[5], 0);
    step(1, 0, 0, 0, 0, 0);
    chk("tp1_err5", error[5], 1);
    chk("tp1_vld_late", bus.to_vld, 0);
    idle();
    chk("tp1_vld", bus.to_vld, 1);
    chk("tp1_id",  bus.to_id,  5);
    step(0, 0, 0, 0, 0, 1);
    chk("tp1_ackvld", bus.to_vld, 0);
    idle();
    chk("tp1_once", bus.to_vld, 0);
    step(0, 0, 0, 1, 5, 0);
    chk("tp1_stop_busy", busy[5], 0);
    chk("tp1_stop_err",  error[5], 0);

    // Stop before threshold
    step(0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2, 0);
    idle(); idle();
    chk("tp2_err", error, '0);
    chk("tp2_vld", bus.to_vld, 0);
    chk("tp2_busy2", busy[2], 0);

    // Disabled threshold, counter saturation, then a max threshold
    thr = 0;
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);
    chk("tp3_busy0", busy[0], 1);
    thr = CNT_W'(CMAX);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    chk("tp3_sat_noexp", error[0], 0);
    step(0, 0, 0, 1, 0, 0);

    // Two channels expiring together, lowest index first
    thr = 2;
    step(0, 1, 7, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle();
    chk("tp4_vld", bus.to_vld, 1);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("tp4_hold_id", bus.to_id, 3);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("tp4_gap", bus.to_vld, 0);
    idle();
    chk("tp4_id7", bus.to_id, 7);
    step(0, 0, 0, 0, 0, 1);
    idle();
    chk("tp4_done", bus.to_vld, 0);
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 1, 7, 0);

    // Protocol violations
    n_proto = 0;
    step(0, 1, 4, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 9, 0);
    step(0, 1, 4, 1, 4, 0);
    idle();
    chk("tp5_pulses", n_proto, 3);
    chk("tp5_busy4",  busy[4], 0);

    // Stop of the reported channel before ack
    thr = 1;
    step(0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle();
    chk("tp6_vld", bus.to_vld, 1);
    chk("tp6_id",  bus.to_id,  1);
    step(0, 0, 0, 1, 1, 0);
    chk("tp6_drop", bus.to_vld, 0);

    // Reset mid-count
    thr = 5;
    for (int i = 10; i < 14; i++) step(0, 1, i, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    rst = 1;
    step(1, 1, 20, 0, 0, 0);
    chk("tp7_busy",  busy,       '0);
    chk("tp7_err",   error,      '0);
    chk("tp7_vld",   bus.to_vld, 0);
    chk("tp7_id",    bus.to_id,  0);
    chk("tp7_proto", proto_err,  0);
    rst = 0;

    // Randomized traffic on a small id range to force collisions
    for (int c = 0; c < 600; c++) begin
      if (c % 24 == 0) thr = CNT_W'($urandom_range(0, 6));
      rst = ($urandom_range(0, 149) == 0);
      step($urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0);
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
